// File: rtl/sar_adc_pkg.sv
// -----------------------------------------------------------------------------
// sar_adc_pkg
// Shared definitions for the SAR ADC scan controller:
//   - sar_state_t : scan controller FSM states
//   - DEF_*       : default values for the controller parameters
//   - sel_width() : width of a channel-select field (never less than 1 bit)
// -----------------------------------------------------------------------------
package sar_adc_pkg;

    localparam int DEF_N_BITS     = 10;
    localparam int DEF_N_CHANNELS = 4;
    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_AVG_LOG2   = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAMPLE  = 3'd1,
        CONVERT = 3'd2,
        ACCUM   = 3'd3,
        OUTPUT  = 3'd4
    } sar_state_t;

    // A single-channel build still needs a 1-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// -----------------------------------------------------------------------------
// sar_bit_engine
// Successive-approximation trial register for one conversion. A start pulse
// loads the MSB trial; each trial lasts CLK_DIV cycles and the comparator is
// sampled on the last cycle of the trial. A 0 clears the bit under test; the
// next lower bit is then set for the following trial.
//
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   start         : one-cycle pulse, begins a conversion on the next edge
//   comparator    : 1 = held input >= current DAC level
//   dac_code      : current trial code, 0 whenever no conversion is running
//   code          : trial register; holds the final code once finished
//   last_trial    : high during the final cycle of the final (LSB) trial
// -----------------------------------------------------------------------------
module sar_bit_engine
    import sar_adc_pkg::*;
#(
    parameter int N_BITS  = DEF_N_BITS,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              comparator,
    output logic [N_BITS-1:0] dac_code,
    output logic [N_BITS-1:0] code,
    output logic              last_trial
);

    localparam int IDX_W = $clog2(N_BITS);
    localparam int DIV_W = $clog2(CLK_DIV);

    logic              active;
    logic [N_BITS-1:0] trial;
    logic [N_BITS-1:0] trial_next;
    logic [IDX_W-1:0]  bit_idx;
    logic [DIV_W-1:0]  div_cnt;
    logic              trial_end;

    assign trial_end  = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign last_trial = trial_end && (bit_idx == '0);
    assign dac_code   = active ? trial : '0;
    assign code       = trial;

    // Resolve the bit under test from the comparator and arm the next bit.
    always_comb begin
        trial_next          = trial;
        trial_next[bit_idx] = comparator;
        if (bit_idx != '0) begin
            trial_next[bit_idx - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active  <= 1'b0;
            trial   <= '0;
            bit_idx <= '0;
            div_cnt <= '0;
        end else if (start) begin
            active  <= 1'b1;
            trial   <= {1'b1, {(N_BITS-1){1'b0}}};
            bit_idx <= IDX_W'(N_BITS - 1);
            div_cnt <= '0;
        end else if (active) begin
            if (trial_end) begin
                div_cnt <= '0;
                trial   <= trial_next;
                if (bit_idx == '0) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx - 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sar_adc_scan_controller.sv
// -----------------------------------------------------------------------------
// sar_adc_scan_controller
// Scans the enabled channels of a multiplexed SAR ADC front end, lowest channel
// first. Each channel is sampled, converted 2^AVG_LOG2 times, averaged and
// handed downstream with a valid/ready handshake. Continuous mode wraps back
// to the lowest enabled channel forever.
//
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   start_digital             : one-cycle scan request (ignored while busy)
//   channel_mask_digital      : enabled channels, latched on accepted start
//   continuous_digital        : rescan forever, latched on accepted start
//   comparator_digital        : 1 = held input >= DAC level
//   result_ready_digital      : downstream ready
//   input_hold_digital        : track/hold switch closed while sampling
//   dac_code_digital          : current trial code (0 outside CONVERT)
//   channel_sel_digital       : analog mux select
//   output_result_digital     : averaged conversion result
//   result_channel_digital    : channel the result belongs to
//   result_valid_digital      : result available, held until ready
//   eoc                       : one-cycle pulse as result_valid rises
//   busy_digital              : scan in progress
//   overrun_digital           : sticky, a start arrived while busy
// -----------------------------------------------------------------------------
module sar_adc_scan_controller
    import sar_adc_pkg::*;
#(
    parameter int N_BITS     = DEF_N_BITS,
    parameter int N_CHANNELS = DEF_N_CHANNELS,
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int AVG_LOG2   = DEF_AVG_LOG2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_digital,
    input  logic [N_CHANNELS-1:0]            channel_mask_digital,
    input  logic                             continuous_digital,
    input  logic                             comparator_digital,
    input  logic                             result_ready_digital,
    output logic                             input_hold_digital,
    output logic [N_BITS-1:0]                dac_code_digital,
    output logic [sel_width(N_CHANNELS)-1:0] channel_sel_digital,
    output logic [N_BITS-1:0]                output_result_digital,
    output logic [sel_width(N_CHANNELS)-1:0] result_channel_digital,
    output logic                             result_valid_digital,
    output logic                             eoc,
    output logic                             busy_digital,
    output logic                             overrun_digital
);

    localparam int CH_W  = sel_width(N_CHANNELS);
    localparam int ACC_W = N_BITS + AVG_LOG2;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int N_AVG = 1 << AVG_LOG2;

    sar_state_t            state;
    logic [DIV_W-1:0]      phase_cnt;
    logic [N_CHANNELS-1:0] mask_lat;
    logic                  cont_lat;
    logic [ACC_W-1:0]      acc;
    logic [3:0]            conv_cnt;

    logic                  eng_start;
    logic                  eng_last;
    logic [N_BITS-1:0]     eng_code;

    // {found, index} of the lowest set mask bit strictly above 'above'.
    logic [CH_W:0]         first_new;
    logic [CH_W:0]         first_lat;
    logic [CH_W:0]         next_lat;

    function automatic logic [CH_W:0] find_chan(input logic [N_CHANNELS-1:0] m,
                                                 input int above);
        logic [CH_W:0] r;
        r = '0;
        // Descending loop so the lowest qualifying channel is the last write.
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (m[i] && (i > above)) begin
                r = {1'b1, CH_W'(i)};
            end
        end
        return r;
    endfunction

    always_comb begin
        first_new = find_chan(channel_mask_digital, -1);
        first_lat = find_chan(mask_lat, -1);
        next_lat  = find_chan(mask_lat, int'(channel_sel_digital));
    end

    // The engine's first trial must line up with the first CONVERT cycle.
    assign eng_start    = (state == SAMPLE) && (phase_cnt == DIV_W'(CLK_DIV - 1));
    assign busy_digital = (state != IDLE);

    sar_bit_engine #(
        .N_BITS  (N_BITS),
        .CLK_DIV (CLK_DIV)
    ) u_bit_engine (
        .clk        (clk),
        .reset      (reset),
        .start      (eng_start),
        .comparator (comparator_digital),
        .dac_code   (dac_code_digital),
        .code       (eng_code),
        .last_trial (eng_last)
    );

    // In OUTPUT the first cycle copies the freshly updated accumulator into
    // the result registers; only afterwards does the handshake run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                  <= IDLE;
            phase_cnt              <= '0;
            mask_lat               <= '0;
            cont_lat               <= 1'b0;
            acc                    <= '0;
            conv_cnt               <= '0;
            input_hold_digital     <= 1'b0;
            channel_sel_digital    <= '0;
            output_result_digital  <= '0;
            result_channel_digital <= '0;
            result_valid_digital   <= 1'b0;
            eoc                    <= 1'b0;
            overrun_digital        <= 1'b0;
        end else begin
            eoc <= 1'b0;

            if (start_digital && (state != IDLE)) begin
                overrun_digital <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_digital && first_new[CH_W]) begin
                        mask_lat            <= channel_mask_digital;
                        cont_lat            <= continuous_digital;
                        channel_sel_digital <= first_new[CH_W-1:0];
                        acc                 <= '0;
                        conv_cnt            <= '0;
                        phase_cnt           <= '0;
                        overrun_digital     <= 1'b0;
                        input_hold_digital  <= 1'b1;
                        state               <= SAMPLE;
                    end
                end

                SAMPLE: begin
                    if (phase_cnt == DIV_W'(CLK_DIV - 1)) begin
                        phase_cnt          <= '0;
                        input_hold_digital <= 1'b0;
                        state              <= CONVERT;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                CONVERT: begin
                    if (eng_last) begin
                        state <= ACCUM;
                    end
                end

                ACCUM: begin
                    acc <= acc + ACC_W'(eng_code);
                    if (int'(conv_cnt) + 1 < N_AVG) begin
                        conv_cnt           <= conv_cnt + 4'd1;
                        phase_cnt          <= '0;
                        input_hold_digital <= 1'b1;
                        state              <= SAMPLE;
                    end else begin
                        conv_cnt <= '0;
                        state    <= OUTPUT;
                    end
                end

                OUTPUT: begin
                    if (!result_valid_digital) begin
                        output_result_digital  <= N_BITS'(acc >> AVG_LOG2);
                        result_channel_digital <= channel_sel_digital;
                        result_valid_digital   <= 1'b1;
                        eoc                    <= 1'b1;
                    end else if (result_ready_digital) begin
                        result_valid_digital <= 1'b0;
                        acc                  <= '0;
                        if (next_lat[CH_W]) begin
                            channel_sel_digital <= next_lat[CH_W-1:0];
                            phase_cnt           <= '0;
                            input_hold_digital  <= 1'b1;
                            state               <= SAMPLE;
                        end else if (cont_lat) begin
                            channel_sel_digital <= first_lat[CH_W-1:0];
                            phase_cnt           <= '0;
                            input_hold_digital  <= 1'b1;
                            state               <= SAMPLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_sar_adc_scan_controller
// Scoreboard bench: two controllers (no averaging, and 4x averaging) driven by
// ideal comparator models. Expected results are queued as stimulus is issued;
// a monitor pops and compares on every eoc pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sar_adc_scan_controller;

    typedef struct packed {
        logic [1:0] ch;
        logic [9:0] val;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main controller (AVG_LOG2 = 0)
    logic       start, cont, ready, comp;
    logic [3:0] mask;
    logic       hold, valid, eoc, busy, ovr;
    logic [9:0] dac, res;
    logic [1:0] csel, rch;
    logic [9:0] level_tab [4];

    assign comp = (level_tab[csel] >= dac);

    // Averaging controller (AVG_LOG2 = 2)
    logic       a_start, a_ready, a_comp;
    logic [3:0] a_mask;
    logic       a_hold, a_valid, a_eoc, a_busy, a_ovr;
    logic [9:0] a_dac, a_res, a_level;
    logic [1:0] a_csel, a_rch;
    int         a_conv_idx = 0;

    always @(posedge a_hold) a_conv_idx++;
    assign a_level = (a_conv_idx % 2 == 1) ? 10'd100 : 10'd103;
    assign a_comp  = (a_level >= a_dac);

    sar_adc_scan_controller #(
        .N_BITS(10), .N_CHANNELS(4), .CLK_DIV(4), .AVG_LOG2(0)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start_digital          (start),
        .channel_mask_digital   (mask),
        .continuous_digital     (cont),
        .comparator_digital     (comp),
        .result_ready_digital   (ready),
        .input_hold_digital     (hold),
        .dac_code_digital       (dac),
        .channel_sel_digital    (csel),
        .output_result_digital  (res),
        .result_channel_digital (rch),
        .result_valid_digital   (valid),
        .eoc                    (eoc),
        .busy_digital           (busy),
        .overrun_digital        (ovr)
    );

    sar_adc_scan_controller #(
        .N_BITS(10), .N_CHANNELS(4), .CLK_DIV(4), .AVG_LOG2(2)
    ) dut_avg (
        .clk                    (clk),
        .reset                  (reset),
        .start_digital          (a_start),
        .channel_mask_digital   (a_mask),
        .continuous_digital     (1'b0),
        .comparator_digital     (a_comp),
        .result_ready_digital   (a_ready),
        .input_hold_digital     (a_hold),
        .dac_code_digital       (a_dac),
        .channel_sel_digital    (a_csel),
        .output_result_digital  (a_res),
        .result_channel_digital (a_rch),
        .result_valid_digital   (a_valid),
        .eoc                    (a_eoc),
        .busy_digital           (a_busy),
        .overrun_digital        (a_ovr)
    );

    exp_t q_main[$];
    exp_t q_avg[$];
    int   eoc_main = 0;
    int   eoc_avg  = 0;
    logic watch_ch2 = 1'b0;
    logic saw_ch2   = 1'b0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every eoc must match the oldest queued expectation.
    always @(negedge clk) begin
        if (eoc === 1'b1) begin
            eoc_main++;
            if (q_main.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_result: got ch %0d val %0d, required none", rch, res);
            end else begin
                exp_t e;
                e = q_main.pop_front();
                checkOutput("result_value", int'(res), int'(e.val));
                checkOutput("result_channel", int'(rch), int'(e.ch));
            end
        end
        if (a_eoc === 1'b1) begin
            eoc_avg++;
            if (q_avg.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_avg_result: got ch %0d val %0d, required none", a_rch, a_res);
            end else begin
                exp_t e;
                e = q_avg.pop_front();
                checkOutput("avg_result_value", int'(a_res), int'(e.val));
                checkOutput("avg_result_channel", int'(a_rch), int'(e.ch));
            end
        end
        if (watch_ch2 && busy && csel == 2'd2) saw_ch2 = 1'b1;
    end

    // Pulse start for one cycle; optionally release reset in the same step.
    task automatic applyStimulus(input logic [3:0] m, input logic c, input logic release_reset);
        @(posedge clk);
        #1;
        if (release_reset) reset = 1'b1;
        mask  = m;
        cont  = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int max_cycles);
        int k;
        k = 0;
        while (busy && k < max_cycles) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput(name, int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles, hold_cnt, dac_at0, dac_at4, dac_at8, unstable, e_before, k, viol;
        logic [9:0] r0;
        logic [1:0] c0;

        reset   = 1'b0;
        start   = 1'b0;
        cont    = 1'b0;
        mask    = 4'b0000;
        ready   = 1'b1;
        a_start = 1'b0;
        a_mask  = 4'b0000;
        a_ready = 1'b1;
        level_tab = '{10'd300, 10'd0, 10'd0, 10'd0};

        // Reset state
        #12;
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_dac", int'(dac), 0);
        checkOutput("reset_hold", int'(hold), 0);
        checkOutput("reset_overrun", int'(ovr), 0);

        // Single channel, level 300, start on first edge after reset release
        $display("[TB] single scan, channel 0, level 300");
        q_main.push_back('{2'd0, 10'd300});
        applyStimulus(4'b0001, 1'b0, 1'b1);
        cycles   = 0;
        hold_cnt = hold ? 1 : 0;
        dac_at0  = int'(dac);
        dac_at4  = -1;
        dac_at8  = -1;
        while (!valid && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (hold) hold_cnt++;
            if (cycles == 4) dac_at4 = int'(dac);
            if (cycles == 8) dac_at8 = int'(dac);
        end
        checkOutput("valid_latency", cycles, 46);
        checkOutput("hold_cycles", hold_cnt, 4);
        checkOutput("dac_in_sample", dac_at0, 0);
        checkOutput("dac_first_trial", dac_at4, 512);
        checkOutput("dac_second_trial", dac_at8, 256);
        checkOutput("eoc_on_rise", int'(eoc), 1);
        @(posedge clk);
        #1;
        checkOutput("eoc_one_cycle", int'(eoc), 0);
        checkOutput("idle_after_single", int'(busy), 0);
        checkOutput("valid_cleared", int'(valid), 0);
        checkOutput("dac_in_idle", int'(dac), 0);

        // Mask 1011, channel 2 must be skipped
        $display("[TB] mask 1011 single scan");
        level_tab = '{10'd0, 10'd1023, 10'd512, 10'd7};
        q_main.push_back('{2'd0, 10'd0});
        q_main.push_back('{2'd1, 10'd1023});
        q_main.push_back('{2'd3, 10'd7});
        saw_ch2   = 1'b0;
        watch_ch2 = 1'b1;
        applyStimulus(4'b1011, 1'b0, 1'b0);
        waitIdle("scan_1011_done", 1000);
        watch_ch2 = 1'b0;
        checkOutput("ch2_skipped", int'(saw_ch2), 0);
        checkOutput("queue_drained_1011", q_main.size(), 0);

        // Back-pressure: ready low for 20 cycles, then start while busy
        $display("[TB] back-pressure and overrun");
        level_tab = '{10'd300, 10'd0, 10'd0, 10'd0};
        ready    = 1'b0;
        e_before = eoc_main;
        q_main.push_back('{2'd0, 10'd300});
        applyStimulus(4'b0001, 1'b0, 1'b0);
        k = 0;
        while (!valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("bp_valid_seen", int'(valid), 1);
        r0 = res;
        c0 = rch;
        unstable = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (res !== r0 || rch !== c0 || valid !== 1'b1) unstable++;
        end
        checkOutput("bp_outputs_stable", unstable, 0);
        checkOutput("bp_single_eoc", eoc_main - e_before, 1);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("overrun_set", int'(ovr), 1);
        checkOutput("busy_in_output", int'(busy), 1);
        checkOutput("result_held_after_start", int'(res), 300);
        ready = 1'b1;
        waitIdle("bp_done", 100);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ignored_start_no_rescan", int'(busy), 0);
        checkOutput("overrun_sticky", int'(ovr), 1);

        // Continuous over channels 1 and 2, then reset mid-conversion
        $display("[TB] continuous scan, mask 0110, reset mid-convert");
        level_tab = '{10'd0, 10'd50, 10'd60, 10'd0};
        q_main.push_back('{2'd1, 10'd50});
        q_main.push_back('{2'd2, 10'd60});
        q_main.push_back('{2'd1, 10'd50});
        q_main.push_back('{2'd2, 10'd60});
        e_before = eoc_main;
        applyStimulus(4'b0110, 1'b1, 1'b0);
        checkOutput("overrun_cleared", int'(ovr), 0);
        k = 0;
        while ((eoc_main - e_before) < 4 && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("continuous_results", eoc_main - e_before, 4);
        k = 0;
        while (dac == 10'd0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("convert_reached", int'(dac != 10'd0), 1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_dac", int'(dac), 0);
        checkOutput("rst_chan_sel", int'(csel), 0);
        checkOutput("rst_result", int'(res), 0);
        checkOutput("rst_result_chan", int'(rch), 0);
        checkOutput("rst_valid", int'(valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle_after_reset", int'(busy), 0);
        checkOutput("no_valid_after_reset", int'(valid), 0);

        // Zero mask start is ignored
        $display("[TB] zero-mask start");
        applyStimulus(4'b0000, 1'b0, 1'b0);
        viol = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (busy || valid) viol++;
        end
        checkOutput("zero_mask_ignored", viol, 0);
        checkOutput("zero_mask_no_overrun", int'(ovr), 0);

        // Averaging controller: levels 100,103,100,103 -> 406 >> 2 = 101
        $display("[TB] 4x averaging");
        a_conv_idx = 0;
        q_avg.push_back('{2'd0, 10'd101});
        @(posedge clk);
        #1;
        a_mask  = 4'b0001;
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        k = 0;
        while (a_busy && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("avg_idle", int'(a_busy), 0);
        checkOutput("avg_conversions", a_conv_idx, 4);
        checkOutput("avg_single_result", eoc_avg, 1);
        checkOutput("avg_queue_drained", q_avg.size(), 0);

        checkOutput("main_queue_drained", q_main.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
